splio_rx: RTL

Serial LED-chain receiver: the far end of the serial LED link driven by the board's parallel-to-serial LED driver. It oversamples `led_clk`, `led_sout`, `led_clrn` and `LED_PEN` on the system clock, shifts bits in, and on the latch strobe presents the reconstructed parallel word. It stands in for the external LED shift-register chain in simulation and on-chip loopback self-test, and reports framing errors.

---
 rtl/splio_pkg.sv | 28 ++
 rtl/splio_rx_sync_edge.sv | 59 +++++
 rtl/splio_rx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/splio_pkg.sv
// Shared definitions for the serial LED-chain receiver.
//   SPLIO_WIDTH   : default frame length in bits
//   SPLIO_CNT_W   : width of the shifted-bit counter (holds up to WIDTH+1)
//   splio_state_t : framing state (IDLE / SHIFT / FULL / OVER)
package splio_pkg;

  localparam int SPLIO_WIDTH = 32;
  localparam int SPLIO_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,   // nothing shifted since last clear/latch
    ST_SHIFT = 2'd1,   // 1 .. WIDTH-1 bits shifted
    ST_FULL  = 2'd2,   // exactly WIDTH bits shifted, latch is legal
    ST_OVER  = 2'd3    // more than WIDTH bits shifted
  } splio_state_t;

  // Saturating increment of the bit counter; sat is the ceiling value.
  function automatic logic [SPLIO_CNT_W-1:0] cnt_inc_sat(
    input logic [SPLIO_CNT_W-1:0] cnt,
    input logic [SPLIO_CNT_W-1:0] sat
  );
    if (cnt >= sat) begin
      return sat;
    end
    return cnt + SPLIO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/splio_rx_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous input.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   async_in  : input from another clock domain / pin
//   level     : synchronized level (after STAGES flops)
//   rise/fall : one-cycle pulses on a synchronized 0->1 / 1->0 transition
module sync_edge
  #(
    parameter int STAGES = 2
  )
  (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
  );

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  // First stage samples the pin; each following stage samples its predecessor.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            chain_reg[gi] <= 1'b0;
          end else begin
            chain_reg[gi] <= async_in;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            chain_reg[gi] <= 1'b0;
          end else begin
            chain_reg[gi] <= chain_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Extra flop holding the previous synchronized value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= chain_reg[STAGES-1];
    end
  end

  assign level = chain_reg[STAGES-1];
  assign rise  = chain_reg[STAGES-1] & ~prev_reg;
  assign fall  = ~chain_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/splio_rx.sv
// Serial LED-chain receiver. Oversamples the serial LED link on clk,
// shifts bits in MSB first and presents the reconstructed word on the
// rising edge of LED_PEN, flagging latches with the wrong bit count.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   led_clk      : serial shift clock (async)
//   led_sout     : serial data, valid at led_clk rising edge
//   led_clrn     : active-low chain clear (level)
//   LED_PEN      : latch enable, rising edge latches the frame
//   P_Data       : last successfully latched frame
//   frame_valid  : one-cycle pulse when P_Data updates
//   frame_err    : one-cycle pulse on a rejected latch
//   bit_cnt      : bits shifted since last clear/latch, saturates at WIDTH+1
module splio_rx
  import splio_pkg::*;
  #(
    parameter int WIDTH       = SPLIO_WIDTH,
    parameter int SYNC_STAGES = 2
  )
  (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   led_clk,
    input  logic                   led_sout,
    input  logic                   led_clrn,
    input  logic                   LED_PEN,
    output logic [WIDTH-1:0]       P_Data,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic [SPLIO_CNT_W-1:0] bit_cnt
  );

  localparam logic [SPLIO_CNT_W-1:0] CNT_LAST = SPLIO_CNT_W'(WIDTH - 1);
  localparam logic [SPLIO_CNT_W-1:0] CNT_SAT  = SPLIO_CNT_W'(WIDTH + 1);

  // ---------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------
  logic lclk_level, lclk_rise, lclk_fall;
  logic sout_level, sout_rise, sout_fall;
  logic clrn_level, clrn_rise, clrn_fall;
  logic pen_level,  pen_rise,  pen_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lclk (
    .clk      (clk),
    .rst      (rst),
    .async_in (led_clk),
    .level    (lclk_level),
    .rise     (lclk_rise),
    .fall     (lclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sout (
    .clk      (clk),
    .rst      (rst),
    .async_in (led_sout),
    .level    (sout_level),
    .rise     (sout_rise),
    .fall     (sout_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clrn (
    .clk      (clk),
    .rst      (rst),
    .async_in (led_clrn),
    .level    (clrn_level),
    .rise     (clrn_rise),
    .fall     (clrn_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pen (
    .clk      (clk),
    .rst      (rst),
    .async_in (LED_PEN),
    .level    (pen_level),
    .rise     (pen_rise),
    .fall     (pen_fall)
  );

  // Synchronizer outputs this receiver has no use for.
  logic unused_sync;
  assign unused_sync = ^{lclk_level, lclk_fall, sout_rise, sout_fall,
                         clrn_rise, clrn_fall, pen_level, pen_fall};

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  splio_state_t           state_reg,  state_next;
  logic [SPLIO_CNT_W-1:0] cnt_reg,    cnt_next;
  logic [WIDTH-1:0]       sr_reg,     sr_next;
  logic [WIDTH-1:0]       p_data_reg, p_data_next;
  logic                   valid_reg,  valid_next;
  logic                   err_reg,    err_next;

  // Post-shift view of the frame, so a shift and a latch edge landing in
  // the same cycle are resolved with the shift applied first.
  splio_state_t           shift_state;
  logic [SPLIO_CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0]       shift_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      sr_reg     <= '0;
      p_data_reg <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sr_reg     <= sr_next;
      p_data_reg <= p_data_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sr_next     = sr_reg;
    p_data_next = p_data_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    shift_state = state_reg;
    shift_cnt   = cnt_reg;
    shift_sr    = sr_reg;

    if (!clrn_level) begin
      // Clear dominates: shifts and latch edges are dropped, no pulses.
      state_next = ST_IDLE;
      cnt_next   = '0;
      sr_next    = '0;
    end else begin
      if (lclk_rise) begin
        shift_sr  = {sr_reg[WIDTH-2:0], sout_level};
        shift_cnt = cnt_inc_sat(cnt_reg, CNT_SAT);
        unique case (state_reg)
          ST_IDLE:  shift_state = ST_SHIFT;
          ST_SHIFT: shift_state = (cnt_reg == CNT_LAST) ? ST_FULL : ST_SHIFT;
          ST_FULL:  shift_state = ST_OVER;
          ST_OVER:  shift_state = ST_OVER;
          default:  shift_state = ST_IDLE;
        endcase
      end

      sr_next = shift_sr;
      if (pen_rise) begin
        if (shift_state == ST_FULL) begin
          p_data_next = shift_sr;
          valid_next  = 1'b1;
        end else begin
          err_next    = 1'b1;
        end
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        state_next = shift_state;
        cnt_next   = shift_cnt;
      end
    end
  end

  assign P_Data      = p_data_reg;
  assign frame_valid = valid_reg;
  assign frame_err   = err_reg;
  assign bit_cnt     = cnt_reg;

endmodule
